// File: rtl/nvme_sq_pkg.sv
// Shared constants and types for the NVMe submission-queue AXI slave.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package nvme_sq_pkg;

    localparam int         SQ_ENTRY_BYTES  = 64;
    localparam logic [2:0] SQ_AXSIZE_ENTRY = 3'd6;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WDATA = 2'd1,
        ST_WRESP = 2'd2,
        ST_RDATA = 2'd3
    } sq_state_e;

endpackage

// File: rtl/sq_slave_mem.sv
// Submission-entry register array: byte-enable write port, combinational read port.
// Latency: write lands on the clock edge, read is combinational (0 cycles).
// Backpressure: none; the owner sequences every access.
module sq_slave_mem #(
    parameter int DEPTH      = 16,
    parameter int IDX_W      = 4,
    parameter int DATA_WIDTH = 512
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    we,
    input  logic [IDX_W-1:0]        widx,
    input  logic [DATA_WIDTH-1:0]   wdat,
    input  logic [DATA_WIDTH/8-1:0] wbe,
    input  logic [IDX_W-1:0]        ridx,
    output logic [DATA_WIDTH-1:0]   rdat
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Clear every entry on reset; merge enabled bytes into the addressed entry on a write
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (wbe[b]) begin
                    mem[widx][b*8 +: 8] <= wdat[b*8 +: 8];
                end
            end
        end
    end

    assign rdat = mem[ridx];

endmodule

// File: rtl/sq_slave.sv
// AXI4 slave holding 16 x 64 B submission entries; one FSM serializes reads and writes (SQ_SLAVE_STRB_EN: honour wstrb).
// Latency: aw/arready one cycle after valid; wready/rvalid one cycle after address accept; bvalid one cycle after last W beat.
// Backpressure: wvalid=0 or rready=0 freezes all state; bvalid held until bready; tied AW/AR alternate grant.
module sq_slave
    import nvme_sq_pkg::*;
#(
    parameter int SQ_ADDR_WIDTH = 10,
    parameter int SQ_DATA_WIDTH = 512,
    parameter int SQ_DEPTH      = 2**SQ_ADDR_WIDTH/(SQ_DATA_WIDTH/8)
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [SQ_ADDR_WIDTH-1:0]   sq_awaddr,
    input  logic [7:0]                 sq_awlen,
    input  logic [2:0]                 sq_awsize,
    input  logic [1:0]                 sq_awburst,
    input  logic                       sq_awvalid,
    output logic                       sq_awready,
    input  logic [SQ_DATA_WIDTH-1:0]   sq_wdata,
    input  logic [SQ_DATA_WIDTH/8-1:0] sq_wstrb,
    input  logic                       sq_wlast,
    input  logic                       sq_wvalid,
    output logic                       sq_wready,
    output logic [1:0]                 sq_bresp,
    output logic                       sq_bvalid,
    input  logic                       sq_bready,
    input  logic [SQ_ADDR_WIDTH-1:0]   sq_araddr,
    input  logic [7:0]                 sq_arlen,
    input  logic [2:0]                 sq_arsize,
    input  logic [1:0]                 sq_arburst,
    input  logic                       sq_arvalid,
    output logic                       sq_arready,
    output logic [SQ_DATA_WIDTH-1:0]   sq_rdata,
    output logic [1:0]                 sq_rresp,
    output logic                       sq_rlast,
    output logic                       sq_rvalid,
    input  logic                       sq_rready
);

    localparam int IDX_LSB = $clog2(SQ_ENTRY_BYTES);
    localparam int IDX_W   = SQ_ADDR_WIDTH - IDX_LSB;
    localparam int STRB_W  = SQ_DATA_WIDTH / 8;

    sq_state_e              state, state_nxt;
    logic                   awready_q, arready_q, last_grant_wr;
    logic [IDX_W-1:0]       idx, idx_adv, mem_ridx;
    logic [7:0]             len, cnt;
    logic [1:0]             burst;
    logic                   size_err, werr;
    logic [SQ_DATA_WIDTH-1:0] rdata_q, mem_rdat;
    logic [STRB_W-1:0]      mem_be;
    logic                   mem_we;
    logic                   aw_hs, ar_hs, w_hs, r_hs, beat_last, grant_wr, grant_rd;
    logic                   unused_bits;

`ifdef SQ_SLAVE_STRB_EN
    assign mem_be      = sq_wstrb;
    assign unused_bits = ^{sq_awaddr[IDX_LSB-1:0], sq_araddr[IDX_LSB-1:0]};
`else
    assign mem_be      = '1;
    assign unused_bits = ^{sq_awaddr[IDX_LSB-1:0], sq_araddr[IDX_LSB-1:0], sq_wstrb};
`endif

    assign sq_awready = awready_q;
    assign sq_arready = arready_q;
    assign sq_rdata   = rdata_q;
    assign mem_we     = w_hs && !size_err;

    // Handshakes, arbitration, index stepping, next state and FSM-decoded outputs
    always_comb begin
        beat_last = (cnt == len);
        aw_hs     = (state == ST_IDLE) && awready_q && sq_awvalid;
        ar_hs     = (state == ST_IDLE) && arready_q && sq_arvalid;
        w_hs      = (state == ST_WDATA) && sq_wvalid;
        r_hs      = (state == ST_RDATA) && sq_rready;
        // On a tie, grant whichever side did not win last time
        grant_wr  = sq_awvalid && (!sq_arvalid || !last_grant_wr);
        grant_rd  = sq_arvalid && !grant_wr;
        idx_adv   = (burst == BURST_FIXED) ? idx : idx + IDX_W'(1);
        // In IDLE the read port pre-fetches the first AR entry; in RDATA the next one
        mem_ridx  = (state == ST_IDLE) ? sq_araddr[SQ_ADDR_WIDTH-1:IDX_LSB] : idx_adv;

        sq_wready = (state == ST_WDATA);
        sq_bvalid = (state == ST_WRESP);
        sq_rvalid = (state == ST_RDATA);
        sq_bresp  = (sq_bvalid && (size_err || werr)) ? RESP_SLVERR : RESP_OKAY;
        sq_rresp  = (sq_rvalid && size_err) ? RESP_SLVERR : RESP_OKAY;
        sq_rlast  = sq_rvalid && beat_last;

        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (aw_hs)      state_nxt = ST_WDATA;
                else if (ar_hs) state_nxt = ST_RDATA;
            end
            ST_WDATA: if (w_hs && beat_last) state_nxt = ST_WRESP;
            ST_WRESP: if (sq_bready)         state_nxt = ST_IDLE;
            ST_RDATA: if (r_hs && beat_last) state_nxt = ST_IDLE;
            default:                         state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Latch burst context on address accept, step index/count per beat, pulse address readies
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            awready_q     <= 1'b0;
            arready_q     <= 1'b0;
            last_grant_wr <= 1'b0;
            idx           <= '0;
            len           <= '0;
            cnt           <= '0;
            burst         <= '0;
            size_err      <= 1'b0;
            werr          <= 1'b0;
            rdata_q       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    awready_q <= 1'b0;
                    arready_q <= 1'b0;
                    if (aw_hs) begin
                        idx      <= sq_awaddr[SQ_ADDR_WIDTH-1:IDX_LSB];
                        len      <= sq_awlen;
                        burst    <= sq_awburst;
                        size_err <= (sq_awsize != SQ_AXSIZE_ENTRY);
                        cnt      <= '0;
                        werr     <= 1'b0;
                    end else if (ar_hs) begin
                        idx      <= sq_araddr[SQ_ADDR_WIDTH-1:IDX_LSB];
                        len      <= sq_arlen;
                        burst    <= sq_arburst;
                        size_err <= (sq_arsize != SQ_AXSIZE_ENTRY);
                        cnt      <= '0;
                        rdata_q  <= (sq_arsize != SQ_AXSIZE_ENTRY) ? '0 : mem_rdat;
                    end else if (!awready_q && !arready_q) begin
                        if (grant_wr) begin
                            awready_q     <= 1'b1;
                            last_grant_wr <= 1'b1;
                        end else if (grant_rd) begin
                            arready_q     <= 1'b1;
                            last_grant_wr <= 1'b0;
                        end
                    end
                end
                ST_WDATA: begin
                    if (w_hs) begin
                        idx <= idx_adv;
                        cnt <= cnt + 8'd1;
                        if (sq_wlast != beat_last) werr <= 1'b1;
                    end
                end
                ST_RDATA: begin
                    if (r_hs && !beat_last) begin
                        idx     <= idx_adv;
                        cnt     <= cnt + 8'd1;
                        rdata_q <= size_err ? '0 : mem_rdat;
                    end
                end
                default: ;
            endcase
        end
    end

    sq_slave_mem #(
        .DEPTH      (SQ_DEPTH),
        .IDX_W      (IDX_W),
        .DATA_WIDTH (SQ_DATA_WIDTH)
    ) u_mem (
        .clk  (clk),
        .rstn (rstn),
        .we   (mem_we),
        .widx (idx),
        .wdat (sq_wdata),
        .wbe  (mem_be),
        .ridx (mem_ridx),
        .rdat (mem_rdat)
    );

endmodule
